// File: rtl/inf_tx.sv
// NEC infrared transmitter: serialises addr/cmd (or a repeat code) into an NEC frame,
// driving a demodulated level and a carrier-modulated LED output.
module inf_tx #(
    parameter int unsigned T_LEAD_MARK  = 450_000,
    parameter int unsigned T_LEAD_SPACE = 225_000,
    parameter int unsigned T_RPT_SPACE  = 112_500,
    parameter int unsigned T_BIT_MARK   = 28_000,
    parameter int unsigned T_SPACE_0    = 28_000,
    parameter int unsigned T_SPACE_1    = 84_500,
    parameter int unsigned T_FRAME      = 5_400_000,
    parameter int unsigned CARRIER_DIV  = 1316,
    parameter int unsigned CARRIER_HIGH = 439
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       start,
    input  logic       rpt_req,
    input  logic [7:0] addr,
    input  logic [7:0] cmd,
    output logic       inf_out,
    output logic       led_out,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_LEAD_MARK  = 3'd1;
    localparam logic [2:0] S_LEAD_SPACE = 3'd2;
    localparam logic [2:0] S_BIT_MARK   = 3'd3;
    localparam logic [2:0] S_BIT_SPACE  = 3'd4;
    localparam logic [2:0] S_STOP_MARK  = 3'd5;
    localparam logic [2:0] S_GAP        = 3'd6;

    localparam logic [18:0] LAST_LEAD_MARK  = 19'(T_LEAD_MARK - 1);
    localparam logic [18:0] LAST_LEAD_SPACE = 19'(T_LEAD_SPACE - 1);
    localparam logic [18:0] LAST_RPT_SPACE  = 19'(T_RPT_SPACE - 1);
    localparam logic [18:0] LAST_BIT_MARK   = 19'(T_BIT_MARK - 1);
    localparam logic [18:0] LAST_SPACE_0    = 19'(T_SPACE_0 - 1);
    localparam logic [18:0] LAST_SPACE_1    = 19'(T_SPACE_1 - 1);
    localparam logic [22:0] LAST_FRAME      = 23'(T_FRAME - 1);
    localparam logic [10:0] LAST_CARRIER    = 11'(CARRIER_DIV - 1);
    localparam logic [10:0] CAR_HIGH        = 11'(CARRIER_HIGH);

    logic [2:0]  state_q, state_d;
    logic [18:0] seg_q, seg_d, seg_last;
    logic [22:0] frame_q, frame_d;
    logic [10:0] car_q, car_d;
    logic [31:0] shift_q, shift_d;
    logic [4:0]  idx_q, idx_d;
    logic        rpt_q, rpt_d;
    logic        sent_q, sent_d;
    logic        inf_q, led_q, busy_q, done_q;
    logic        seg_done, boundary, mark_d;

    always_comb begin
        case (state_q)
            S_LEAD_MARK:  seg_last = LAST_LEAD_MARK;
            S_LEAD_SPACE: seg_last = rpt_q ? LAST_RPT_SPACE : LAST_LEAD_SPACE;
            S_BIT_MARK:   seg_last = LAST_BIT_MARK;
            S_BIT_SPACE:  seg_last = shift_q[0] ? LAST_SPACE_1 : LAST_SPACE_0;
            S_STOP_MARK:  seg_last = LAST_BIT_MARK;
            default:      seg_last = '0;
        endcase
    end

    assign seg_done = (seg_q == seg_last);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        rpt_d   = rpt_q;
        sent_d  = sent_q;
        frame_d = (state_q != S_IDLE) ? frame_q + 23'd1 : frame_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shift_d = {~cmd, cmd, ~addr, addr};
                    rpt_d   = 1'b0;
                    frame_d = '0;
                    state_d = S_LEAD_MARK;
                end else if (rpt_req && sent_q) begin
                    rpt_d   = 1'b1;
                    frame_d = '0;
                    state_d = S_LEAD_MARK;
                end
            end
            S_LEAD_MARK:  if (seg_done) state_d = S_LEAD_SPACE;
            S_LEAD_SPACE: begin
                if (seg_done) begin
                    idx_d   = '0;
                    state_d = rpt_q ? S_STOP_MARK : S_BIT_MARK;
                end
            end
            S_BIT_MARK:   if (seg_done) state_d = S_BIT_SPACE;
            S_BIT_SPACE: begin
                if (seg_done) begin
                    shift_d = {1'b0, shift_q[31:1]};
                    idx_d   = idx_q + 5'd1;
                    state_d = (idx_q == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
                end
            end
            S_STOP_MARK: begin
                if (seg_done) begin
                    if (!rpt_q) sent_d = 1'b1;
                    state_d = S_GAP;
                end
            end
            S_GAP:        if (frame_q >= LAST_FRAME) state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    // Every segment end is a state change, so the boundary restarts both counters.
    assign boundary = (state_d != state_q);
    assign mark_d   = (state_d == S_LEAD_MARK) || (state_d == S_BIT_MARK) ||
                      (state_d == S_STOP_MARK);

    always_comb begin
        seg_d = '0;
        car_d = '0;
        if (!boundary && state_q != S_IDLE && state_q != S_GAP) seg_d = seg_q + 19'd1;
        if (!boundary && mark_d) car_d = (car_q == LAST_CARRIER) ? '0 : car_q + 11'd1;
    end

    // Outputs are decoded from next-state values so all four flop on the same edge.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
            seg_q   <= '0;
            frame_q <= '0;
            car_q   <= '0;
            shift_q <= '0;
            idx_q   <= '0;
            rpt_q   <= 1'b0;
            sent_q  <= 1'b0;
            inf_q   <= 1'b1;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
            frame_q <= frame_d;
            car_q   <= car_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            rpt_q   <= rpt_d;
            sent_q  <= sent_d;
            inf_q   <= ~mark_d;
            led_q   <= mark_d && (car_d < CAR_HIGH);
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_q == S_GAP) && (state_d == S_IDLE);
        end
    end

    assign inf_out = inf_q;
    assign led_out = led_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_inf_tx.sv
// Directed bench for inf_tx using shortened segment lengths so each frame is a few
// hundred clocks; every inf_out run length and carrier cycle is checked against hand values.
module tb_inf_tx;

    localparam int LM  = 40;   // leader mark
    localparam int LS  = 20;   // data leader space
    localparam int RS  = 10;   // repeat leader space
    localparam int BM  = 4;    // bit / stop mark
    localparam int S0  = 4;
    localparam int S1  = 12;
    localparam int TF  = 600;
    localparam int CD  = 6;
    localparam int CH  = 2;
    localparam int DATA_ACTIVE = LM + LS + 33 * BM + 16 * S0 + 16 * S1;  // 448
    localparam int RPT_ACTIVE  = LM + RS + BM;                           // 54

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       rpt_req = 1'b0;
    logic [7:0] addr = '0;
    logic [7:0] cmd = '0;
    logic       inf_out, led_out, busy, done;

    int total = 0;
    int bad   = 0;
    int runs[$];
    int exp_runs[$];

    inf_tx #(
        .T_LEAD_MARK (LM), .T_LEAD_SPACE(LS), .T_RPT_SPACE(RS), .T_BIT_MARK(BM),
        .T_SPACE_0   (S0), .T_SPACE_1   (S1), .T_FRAME    (TF),
        .CARRIER_DIV (CD), .CARRIER_HIGH(CH)
    ) dut (
        .sys_clk(clk), .sys_rst(rst), .start(start), .rpt_req(rpt_req),
        .addr(addr), .cmd(cmd), .inf_out(inf_out), .led_out(led_out),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Records inf_out run lengths from the current (first busy) sample until busy falls,
    // and checks led_out against the carrier phase within each mark.
    task automatic run_frame(input bit b2b, input int chg_cycle, output int n,
                             output bit done_seen, output int led_err, output int done_err);
        logic lvl;
        int   len;
        bit   exp_led;
        runs.delete();
        n = 0; led_err = 0; done_err = 0; len = 0; lvl = 1'b1;
        while (busy === 1'b1 && n < 2 * TF) begin
            if (n == 0 || inf_out !== lvl) begin
                if (n > 0) runs.push_back(len);
                lvl = inf_out;
                len = 0;
            end
            exp_led = (lvl == 1'b0) ? ((len % CD) < CH) : 1'b0;
            if (led_out !== exp_led) led_err++;
            if (done !== 1'b0) done_err++;
            len++;
            if (n == chg_cycle) begin
                addr = 8'hFF; cmd = 8'h00; start = 1'b1; rpt_req = 1'b1;
            end else if (n == chg_cycle + 1) begin
                start = 1'b0; rpt_req = 1'b0;
            end
            tick();
            n++;
        end
        runs.push_back(len);
        done_seen = done;
        if (b2b) start = 1'b1;
    endtask

    function automatic logic [31:0] decode_runs();
        logic [31:0] w = '0;
        for (int i = 0; i < 32; i++)
            if (runs.size() > 3 + 2 * i) w[i] = (runs[3 + 2 * i] > (S0 + S1) / 2);
        return w;
    endfunction

    function automatic void build_data_exp(input logic [31:0] w);
        exp_runs.delete();
        exp_runs.push_back(LM);
        exp_runs.push_back(LS);
        for (int i = 0; i < 32; i++) begin
            exp_runs.push_back(BM);
            exp_runs.push_back(w[i] ? S1 : S0);
        end
        exp_runs.push_back(BM);
        exp_runs.push_back(TF - DATA_ACTIVE);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        total++; if (inf_out !== 1'b1) begin bad++; $display("FAIL reset_inf_out got=%b want=1", inf_out); end
        total++; if (led_out !== 1'b0) begin bad++; $display("FAIL reset_led_out got=%b want=0", led_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_rpt_without_frame();
        int busy_seen = 0;
        rpt_req = 1'b1;
        tick();
        rpt_req = 1'b0;
        repeat (20) begin
            if (busy !== 1'b0 || inf_out !== 1'b1) busy_seen++;
            tick();
        end
        total++; if (busy_seen != 0) begin bad++; $display("FAIL rpt_no_frame active_cycles got=%0d want=0", busy_seen); end
    endtask

    task automatic test_data_frame();
        int n, led_err, done_err, run_err;
        bit done_seen;
        addr = 8'h00; cmd = 8'h45;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (busy !== 1'b1 || inf_out !== 1'b0 || led_out !== 1'b1) begin
            bad++; $display("FAIL data_first_cycle got busy=%b inf=%b led=%b want 1 0 1", busy, inf_out, led_out);
        end
        run_frame(1'b0, -10, n, done_seen, led_err, done_err);
        total++; if (n != TF) begin bad++; $display("FAIL data_busy_len got=%0d want=%0d", n, TF); end
        total++; if (done_seen !== 1'b1) begin bad++; $display("FAIL data_done got=%b want=1", done_seen); end
        total++; if (done_err != 0) begin bad++; $display("FAIL data_done_early got=%0d want=0", done_err); end
        total++; if (led_err != 0) begin bad++; $display("FAIL data_carrier errors got=%0d want=0", led_err); end
        total++; if (decode_runs() !== 32'hBA45FF00) begin
            bad++; $display("FAIL data_word got=%h want=ba45ff00", decode_runs());
        end
        build_data_exp(32'hBA45FF00);
        total++; if (runs.size() != exp_runs.size()) begin
            bad++; $display("FAIL data_run_count got=%0d want=%0d", runs.size(), exp_runs.size());
        end
        run_err = 0;
        for (int i = 0; i < exp_runs.size() && i < runs.size(); i++)
            if (runs[i] != exp_runs[i]) begin
                run_err++;
                $display("FAIL data_run[%0d] got=%0d want=%0d", i, runs[i], exp_runs[i]);
            end
        total++; if (run_err != 0) bad++;
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL data_done_width got=%b want=0", done); end
    endtask

    task automatic test_repeat();
        int n, led_err, done_err;
        bit done_seen;
        rpt_req = 1'b1;
        tick();
        rpt_req = 1'b0;
        run_frame(1'b0, -10, n, done_seen, led_err, done_err);
        total++; if (n != TF) begin bad++; $display("FAIL rpt_busy_len got=%0d want=%0d", n, TF); end
        total++; if (done_seen !== 1'b1) begin bad++; $display("FAIL rpt_done got=%b want=1", done_seen); end
        total++; if (led_err != 0) begin bad++; $display("FAIL rpt_carrier errors got=%0d want=0", led_err); end
        total++; if (runs.size() != 4) begin
            bad++; $display("FAIL rpt_run_count got=%0d want=4", runs.size());
        end else if (runs[0] != LM || runs[1] != RS || runs[2] != BM || runs[3] != TF - RPT_ACTIVE) begin
            bad++; $display("FAIL rpt_runs got=%0d/%0d/%0d/%0d want=%0d/%0d/%0d/%0d", runs[0], runs[1],
                            runs[2], runs[3], LM, RS, BM, TF - RPT_ACTIVE);
        end
        tick();
    endtask

    task automatic test_start_and_rpt();
        int n, led_err, done_err;
        bit done_seen;
        addr = 8'hA5; cmd = 8'h0F;
        start = 1'b1; rpt_req = 1'b1;
        tick();
        start = 1'b0; rpt_req = 1'b0;
        run_frame(1'b0, -10, n, done_seen, led_err, done_err);
        total++; if (runs.size() != 68) begin bad++; $display("FAIL both_run_count got=%0d want=68", runs.size()); end
        total++; if (decode_runs() !== 32'hF00F5AA5) begin
            bad++; $display("FAIL both_word got=%h want=f00f5aa5", decode_runs());
        end
        tick();
    endtask

    task automatic test_addr_change();
        int n, led_err, done_err, busy_seen;
        bit done_seen;
        addr = 8'h12; cmd = 8'h34;
        start = 1'b1;
        tick();
        start = 1'b0;
        // cycle 164 is the first mark cycle of bit 10 for payload 0xCB34ED12
        run_frame(1'b0, 164, n, done_seen, led_err, done_err);
        total++; if (decode_runs() !== 32'hCB34ED12) begin
            bad++; $display("FAIL chg_word got=%h want=cb34ed12", decode_runs());
        end
        total++; if (n != TF) begin bad++; $display("FAIL chg_busy_len got=%0d want=%0d", n, TF); end
        busy_seen = 0;
        repeat (20) begin
            if (busy !== 1'b0) busy_seen++;
            tick();
        end
        total++; if (busy_seen != 0) begin bad++; $display("FAIL chg_no_second_frame got=%0d want=0", busy_seen); end
    endtask

    task automatic test_back_to_back();
        int n, led_err, done_err;
        bit done_seen;
        addr = 8'h00; cmd = 8'h45;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_frame(1'b1, -10, n, done_seen, led_err, done_err);
        total++; if (done_seen !== 1'b1) begin bad++; $display("FAIL b2b_done got=%b want=1", done_seen); end
        tick();
        start = 1'b0;
        total++; if (busy !== 1'b1 || inf_out !== 1'b0) begin
            bad++; $display("FAIL b2b_accept got busy=%b inf=%b want 1 0", busy, inf_out);
        end
        run_frame(1'b0, -10, n, done_seen, led_err, done_err);
        total++; if (n != TF) begin bad++; $display("FAIL b2b_busy_len got=%0d want=%0d", n, TF); end
        tick();
    endtask

    task automatic test_reset_mid_frame();
        int busy_seen = 0;
        addr = 8'h00; cmd = 8'h45;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (65) tick();
        total++; if (inf_out !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL midrst_in_space got inf=%b busy=%b want 1 1", inf_out, busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (inf_out !== 1'b1 || led_out !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL midrst_outputs got inf=%b led=%b busy=%b want 1 0 0", inf_out, led_out, busy);
        end
        rpt_req = 1'b1;
        tick();
        rpt_req = 1'b0;
        repeat (20) begin
            if (busy !== 1'b0) busy_seen++;
            tick();
        end
        total++; if (busy_seen != 0) begin bad++; $display("FAIL midrst_rpt_ignored got=%0d want=0", busy_seen); end
    endtask

    initial begin
        test_reset();
        test_rpt_without_frame();
        test_data_frame();
        test_repeat();
        test_start_and_rpt();
        test_addr_change();
        test_back_to_back();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
